// File: rtl/online_pkg.sv
// Shared definitions for the online (redundant-digit) filter sections.
// Contents:
//   NDIG_OFFSET : digit-count offset over the pole precision (NDIG = Stage + 13)
//   DIG_POS     : borrow-save digit code for +1 (p=1, n=0)
//   DIG_NEG     : borrow-save digit code for -1 (p=0, n=1)
//   state_t     : serial-converter FSM states
package online_pkg;

   localparam int NDIG_OFFSET = 13;

   localparam logic [1:0] DIG_POS = 2'b10;
   localparam logic [1:0] DIG_NEG = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/online_otf_step.sv
// One-digit on-the-fly conversion step (combinational).
// Q holds the converted prefix, QM holds Q-1; both shift left by one
// position and append a bit chosen by the incoming signed digit.
// Ports:
//   q, qm           : current Q / QM registers (W bits)
//   dig             : borrow-save digit {p, n}; 00 and 11 both mean 0
//   q_next, qm_next : updated Q / QM
module online_otf_step
   import online_pkg::*;
#(
   parameter int W = 22
) (
   input  logic [W-1:0] q,
   input  logic [W-1:0] qm,
   input  logic [1:0]   dig,
   output logic [W-1:0] q_next,
   output logic [W-1:0] qm_next
);

   always_comb begin
      // digit 0 (codes 00 and 11)
      q_next  = q << 1;
      qm_next = (qm << 1) | W'(1);
      case (dig)
         DIG_POS: begin
            q_next  = (q << 1) | W'(1);
            qm_next = q << 1;
         end
         DIG_NEG: begin
            q_next  = (qm << 1) | W'(1);
            qm_next = qm << 1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/online_rd2tc_serial.sv
// Borrow-save to two's-complement serial converter.
// Accepts one parallel borrow-save word, converts it MSB-first at one digit
// per clock with an on-the-fly converter, and presents the result with a
// valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// CONV  | consuming one digit per cycle, busy=1
// DONE  | result held on dout, out_valid=1 until out_ready
//
// Ports:
//   clk, nrst           : clock, asynchronous active-low reset
//   din, in_valid       : borrow-save input word (digit i = din[2i+1:2i], {p,n})
//   in_ready            : word accepted on this edge when in_valid is high
//   dout, out_valid     : two's-complement result (NDIG+1 bits) and its valid
//   out_ready           : consumer takes dout
//   busy                : conversion in progress
module online_rd2tc_serial
   import online_pkg::*;
#(
   parameter int Stage = 8,
   localparam int NDIG = Stage + NDIG_OFFSET
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [2*NDIG-1:0] din,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [NDIG:0]     dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int W  = NDIG + 1;
   localparam int CW = $clog2(NDIG);

   state_t              state;
   logic [2*NDIG-1:0]   sreg;
   logic [W-1:0]        q;
   logic [W-1:0]        qm;
   logic [W-1:0]        q_nx;
   logic [W-1:0]        qm_nx;
   logic [CW-1:0]       cnt;
   logic                idle_rdy;
   logic                accept;

   // idle_rdy mirrors state==IDLE but stays low during reset so in_ready
   // only rises on the first edge after release.
   assign in_ready = idle_rdy | (out_valid & out_ready);
   assign accept   = in_valid & in_ready;
   assign dout     = q;

   online_otf_step #(.W(W)) u_step (
      .q       (q),
      .qm      (qm),
      .dig     (sreg[2*NDIG-1 -: 2]),
      .q_next  (q_nx),
      .qm_next (qm_nx)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         sreg      <= '0;
         q         <= '0;
         qm        <= '1;
         cnt       <= '0;
         idle_rdy  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sreg     <= din;
                  q        <= '0;
                  qm       <= '1;
                  cnt      <= CW'(NDIG - 1);
                  state    <= CONV;
                  busy     <= 1'b1;
                  idle_rdy <= 1'b0;
               end else begin
                  idle_rdy <= 1'b1;
               end
            end
            CONV: begin
               q    <= q_nx;
               qm   <= qm_nx;
               sreg <= sreg << 2;
               if (cnt == '0) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     // retire and capture on the same edge
                     sreg  <= din;
                     q     <= '0;
                     qm    <= '1;
                     cnt   <= CW'(NDIG - 1);
                     state <= CONV;
                     busy  <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     idle_rdy <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               idle_rdy <= 1'b0;
               busy     <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_online_rd2tc_serial.sv
// Self-checking bench for online_rd2tc_serial at Stage=8 (NDIG=21).
// A queue-based model predicts the converted value (signed digit sum),
// the latency and the handshake levels; directed words pin the model.
module tb_online_rd2tc_serial;

   localparam int STAGE = 8;
   localparam int NDIG  = STAGE + 13;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic [2*NDIG-1:0] din = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NDIG:0]     dout;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              busy;

   online_rd2tc_serial #(.Stage(STAGE)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .din       (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dout      (dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit live     = 0;

   logic [NDIG:0] exp_q[$];
   int            acc_q[$];

   function automatic logic [NDIG:0] ref_val(input logic [2*NDIG-1:0] w);
      longint acc;
      acc = 0;
      for (int i = 0; i < NDIG; i++)
         acc = acc + (longint'(w[2*i+1]) - longint'(w[2*i])) * (longint'(1) << i);
      return acc[NDIG:0];
   endfunction

   function automatic bit model_ov();
      return (exp_q.size() > 0) && (cyc - acc_q[0] - 1 >= NDIG);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // model update on every edge
   always @(posedge clk) begin
      bit ov, rdy;
      if (!nrst) begin
         exp_q.delete();
         acc_q.delete();
         live = 0;
      end else begin
         ov  = model_ov();
         rdy = live && ((exp_q.size() == 0) || (ov && out_ready));
         if (ov && out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
         end
         if (in_valid && rdy) begin
            exp_q.push_back(ref_val(din));
            acc_q.push_back(cyc);
         end
         live = 1;
      end
      cyc++;
   end

   // compare process
   always @(negedge clk) begin
      bit ov;
      if (nrst) begin
         if (!live) begin
            chk("in_ready_before_first_edge", in_ready, 0);
         end else begin
            ov = model_ov();
            chk("out_valid", out_valid, ov);
            chk("busy", busy, (exp_q.size() > 0) && !ov);
            chk("in_ready", in_ready, (exp_q.size() == 0) || (ov && out_ready));
            if (ov) chk("dout", dout, exp_q[0]);
         end
      end
   end

   task automatic send(input logic [2*NDIG-1:0] w);
      int n;
      din      = w;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            fail_now("send");
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      din      = ~w;   // must be ignored after the accept edge
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         n++;
         if (n > 100) begin
            fail_now(name);
            return;
         end
      end
   endtask

   task automatic run_lit(input string name, input logic [2*NDIG-1:0] w, input logic [NDIG:0] lit);
      chk({name, "_model"}, ref_val(w), lit);
      send(w);
      wait_valid(name);
      chk(name, dout, lit);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2*NDIG-1:0] w;
      logic [NDIG:0]     held;

      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dout", dout, 0);
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", in_ready, 1);

      run_lit("zero",      42'h0,             22'h000000);
      run_lit("d0_pos",    42'h2,             22'h000001);
      run_lit("d1p_d0n",   42'h9,             22'h000001);
      run_lit("d20_neg",   42'h100_0000_0000, 22'h300000);
      run_lit("all_pos",   42'h2AA_AAAA_AAAA, 22'h1FFFFF);
      run_lit("all_neg",   42'h155_5555_5555, 22'h200001);
      run_lit("all_11",    42'h3FF_FFFF_FFFF, 22'h000000);

      // stall in DONE, then retire and accept on the same edge
      out_ready = 1'b0;
      send(42'h2AA_AAAA_AAAA);
      wait_valid("stall");
      held = dout;
      chk("stall_value", held, 22'h1FFFFF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_dout", dout, held);
         chk("stall_valid", out_valid, 1);
         chk("stall_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      din       = 42'h155_5555_5555;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_valid", out_valid, 0);
      wait_valid("b2b");
      chk("b2b_value", dout, 22'h200001);
      @(posedge clk);
      #1;

      // reset in the middle of a conversion
      send(42'h2AA_AAAA_AAAA);
      repeat (7) @(posedge clk);
      #3 nrst = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_dout", dout, 0);
      chk("abort_in_ready", in_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1 nrst = 1'b1;
      @(posedge clk);
      #1;
      run_lit("after_abort", 42'h100_0000_0002, 22'h300001);

      // random words, back-to-back through DONE
      for (int k = 0; k < 1000; k++) begin
         w[31:0]  = $urandom();
         w[41:32] = 10'($urandom());
         send(w);
      end
      wait_valid("rand_last");
      @(posedge clk);
      #1;
      repeat (3) @(posedge clk);
      #1;
      chk("drain_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
